// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi: 24h HH:MM timekeeper with NUM_ALARMS programmable alarms, snooze, dismiss and auto-timeout.
// Ports: clk, rst (sync active-high); set_time/set_hours/set_minutes load the time;
//        alm_wr/alm_sel/alm_hours/alm_minutes/alm_enable program one alarm channel;
//        snooze/dismiss strobes; cur_hours/cur_minutes current time; ringing/snoozing FSM state;
//        ring_id channel that started the episode; buzzer piezo drive.
// Optional: define ALARM_BEEP_EN for a BEEP_HALF-cycle square-wave buzzer, otherwise buzzer follows ringing.
module alarm_clock_multi #(
    parameter int TICKS_PER_MIN = 60_000_000,
    parameter int NUM_ALARMS = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MAX_MIN = 2,
    parameter int BEEP_HALF = 1000,
    localparam int AW = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_time,
    input  logic [4:0]    set_hours,
    input  logic [5:0]    set_minutes,
    input  logic          alm_wr,
    input  logic [AW-1:0] alm_sel,
    input  logic [4:0]    alm_hours,
    input  logic [5:0]    alm_minutes,
    input  logic          alm_enable,
    input  logic          snooze,
    input  logic          dismiss,
    output logic [4:0]    cur_hours,
    output logic [5:0]    cur_minutes,
    output logic          ringing,
    output logic          snoozing,
    output logic [AW-1:0] ring_id,
    output logic          buzzer
);
    localparam int PW = $clog2(TICKS_PER_MIN);
    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
    state_t state, state_n;
    logic [PW-1:0] pre;
    logic [4:0] nxt_h;
    logic [5:0] nxt_m;
    logic set_ok, wr_ok, min_tick, hit;
    logic [AW-1:0] hit_id, id_n;
    logic [4:0] a_h [NUM_ALARMS];
    logic [5:0] a_m [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] a_en;
    logic [3:0] rc, rc_n, sc, sc_n;
    assign set_ok = set_time && set_hours <= 5'd23 && set_minutes <= 6'd59;
    assign wr_ok = alm_wr && int'(alm_sel) < NUM_ALARMS && alm_hours <= 5'd23 && alm_minutes <= 6'd59;
    // a load in the same cycle suppresses the wrap, so it never counts as a minute
    assign min_tick = pre == PW'(TICKS_PER_MIN - 1) && !set_ok;
    assign nxt_m = cur_minutes == 6'd59 ? 6'd0 : cur_minutes + 6'd1;
    assign nxt_h = cur_minutes != 6'd59 ? cur_hours : cur_hours == 5'd23 ? 5'd0 : cur_hours + 5'd1;
    assign ringing = state == RING;
    assign snoozing = state == SNOOZE;
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            cur_hours <= '0;
            cur_minutes <= '0;
        end else if (set_ok) begin
            pre <= '0;
            cur_hours <= set_hours;
            cur_minutes <= set_minutes;
        end else if (min_tick) begin
            pre <= '0;
            cur_hours <= nxt_h;
            cur_minutes <= nxt_m;
        end else
            pre <= pre + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                a_h[i] <= '0;
                a_m[i] <= '0;
            end
            a_en <= '0;
        end else if (wr_ok) begin
            a_h[alm_sel] <= alm_hours;
            a_m[alm_sel] <= alm_minutes;
            a_en[alm_sel] <= alm_enable;
        end
    end
    // compared against the time the tick is about to show; descending scan leaves the lowest index
    always_comb begin
        hit = 1'b0;
        hit_id = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--)
            if (min_tick && a_en[i] && a_h[i] == nxt_h && a_m[i] == nxt_m) begin
                hit = 1'b1;
                hit_id = AW'(i);
            end
    end
    always_comb begin
        state_n = state;
        id_n = ring_id;
        rc_n = rc;
        sc_n = sc;
        case (state)
            IDLE:
                if (hit) begin
                    state_n = RING;
                    id_n = hit_id;
                    rc_n = '0;
                end
            RING:
                if (dismiss)
                    state_n = IDLE;
                else if (snooze) begin
                    state_n = SNOOZE;
                    sc_n = 4'(SNOOZE_MIN);
                end else if (min_tick) begin
                    if (rc == 4'(RING_MAX_MIN - 1)) begin
                        // a fresh match on the timeout tick starts a new episode
                        state_n = hit ? RING : IDLE;
                        id_n = hit ? hit_id : ring_id;
                        rc_n = '0;
                    end else
                        rc_n = rc + 4'd1;
                end
            SNOOZE:
                if (dismiss)
                    state_n = IDLE;
                else if (min_tick) begin
                    if (sc == 4'd1) begin
                        state_n = RING;
                        rc_n = '0;
                    end else
                        sc_n = sc - 4'd1;
                end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ring_id <= '0;
            rc <= '0;
            sc <= '0;
        end else begin
            state <= state_n;
            ring_id <= id_n;
            rc <= rc_n;
            sc <= sc_n;
        end
    end
`ifdef ALARM_BEEP_EN
    logic [31:0] bc;
    logic enter;
    assign enter = state_n == RING && (state != RING || (min_tick && rc == 4'(RING_MAX_MIN - 1)));
    always_ff @(posedge clk) begin
        if (rst || state_n != RING) begin
            buzzer <= 1'b0;
            bc <= '0;
        end else if (enter) begin
            buzzer <= 1'b1;
            bc <= '0;
        end else if (bc == 32'(BEEP_HALF - 1)) begin
            buzzer <= ~buzzer;
            bc <= '0;
        end else
            bc <= bc + 32'd1;
    end
`else
    assign buzzer = ringing;
`endif
endmodule

// File: tb/tb_alarm_clock_multi.sv
// tb_alarm_clock_multi: directed self-checking bench for alarm_clock_multi.
module tb_alarm_clock_multi;
    logic clk = 0, rst = 1, set_time = 0, alm_wr = 0, alm_enable = 0, snooze = 0, dismiss = 0;
    logic [4:0] set_hours = 0, alm_hours = 0, cur_hours;
    logic [5:0] set_minutes = 0, alm_minutes = 0, cur_minutes;
    logic [1:0] alm_sel = 0, ring_id;
    logic ringing, snoozing, buzzer;
    int total = 0, bad = 0;

    alarm_clock_multi #(.TICKS_PER_MIN(4), .NUM_ALARMS(4), .SNOOZE_MIN(2), .RING_MAX_MIN(2), .BEEP_HALF(3)) dut (
        .clk(clk), .rst(rst), .set_time(set_time), .set_hours(set_hours), .set_minutes(set_minutes),
        .alm_wr(alm_wr), .alm_sel(alm_sel), .alm_hours(alm_hours), .alm_minutes(alm_minutes),
        .alm_enable(alm_enable), .snooze(snooze), .dismiss(dismiss), .cur_hours(cur_hours),
        .cur_minutes(cur_minutes), .ringing(ringing), .snoozing(snoozing), .ring_id(ring_id), .buzzer(buzzer));

    always #5 clk = ~clk;

    task cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task set_t(input logic [4:0] h, input logic [5:0] m);
        set_time = 1; set_hours = h; set_minutes = m;
        cyc(1);
        set_time = 0;
    endtask

    task wr(input logic [1:0] s, input logic [4:0] h, input logic [5:0] m, input logic en);
        alm_wr = 1; alm_sel = s; alm_hours = h; alm_minutes = m; alm_enable = en;
        cyc(1);
        alm_wr = 0;
    endtask

    task pulse(input logic sn, input logic di);
        snooze = sn; dismiss = di;
        cyc(1);
        snooze = 0; dismiss = 0;
    endtask

    task test_reset;
        rst = 1;
        cyc(2);
        rst = 0;
        total++; if ({cur_hours, cur_minutes} !== 11'd0) begin bad++; $display("FAIL reset_time got=%0d:%0d exp=0:0", cur_hours, cur_minutes); end
        total++; if ({ringing, snoozing, buzzer, ring_id} !== 5'd0) begin bad++; $display("FAIL reset_outs got=%b exp=00000", {ringing, snoozing, buzzer, ring_id}); end
    endtask

    task test_timekeeping;
        set_t(23, 58);
        total++; if ({cur_hours, cur_minutes} !== {5'd23, 6'd58}) begin bad++; $display("FAIL set_time got=%0d:%0d exp=23:58", cur_hours, cur_minutes); end
        cyc(3);
        total++; if (cur_minutes !== 6'd58) begin bad++; $display("FAIL pre_tick got=%0d exp=58", cur_minutes); end
        cyc(1);
        total++; if ({cur_hours, cur_minutes} !== {5'd23, 6'd59}) begin bad++; $display("FAIL tick_2359 got=%0d:%0d exp=23:59", cur_hours, cur_minutes); end
        cyc(4);
        total++; if ({cur_hours, cur_minutes} !== 11'd0) begin bad++; $display("FAIL wrap_0000 got=%0d:%0d exp=0:0", cur_hours, cur_minutes); end
        set_t(24, 10);
        total++; if ({cur_hours, cur_minutes} !== 11'd0) begin bad++; $display("FAIL bad_hours got=%0d:%0d exp=0:0", cur_hours, cur_minutes); end
        set_t(12, 60);
        total++; if ({cur_hours, cur_minutes} !== 11'd0) begin bad++; $display("FAIL bad_minutes got=%0d:%0d exp=0:0", cur_hours, cur_minutes); end
        set_t(9, 59);
        cyc(4);
        total++; if ({cur_hours, cur_minutes} !== {5'd10, 6'd0}) begin bad++; $display("FAIL hour_carry got=%0d:%0d exp=10:0", cur_hours, cur_minutes); end
    endtask

    task test_match;
        wr(1, 7, 1, 1);
        set_t(7, 0);
        cyc(3);
        total++; if (ringing !== 1'b0) begin bad++; $display("FAIL early_ring got=%b exp=0", ringing); end
        cyc(1);
        total++; if ({ringing, ring_id, buzzer, cur_minutes} !== {1'b1, 2'd1, 1'b1, 6'd1}) begin bad++; $display("FAIL ring_alm1 got=%b/%0d/%b/%0d exp=1/1/1/1", ringing, ring_id, buzzer, cur_minutes); end
        pulse(0, 1);
        total++; if ({ringing, snoozing, buzzer} !== 3'b000) begin bad++; $display("FAIL dismiss got=%b exp=000", {ringing, snoozing, buzzer}); end
        set_t(7, 1);
        cyc(1);
        total++; if (ringing !== 1'b0) begin bad++; $display("FAIL set_no_match got=%b exp=0", ringing); end
    endtask

    task test_priority;
        wr(1, 7, 1, 0);
        wr(2, 7, 1, 1);
        wr(0, 7, 1, 1);
        set_t(7, 0);
        cyc(4);
        total++; if ({ringing, ring_id} !== {1'b1, 2'd0}) begin bad++; $display("FAIL prio_low got=%b/%0d exp=1/0", ringing, ring_id); end
        pulse(0, 1);
        wr(0, 7, 1, 0);
        set_t(7, 0);
        cyc(4);
        total++; if ({ringing, ring_id} !== {1'b1, 2'd2}) begin bad++; $display("FAIL prio_next got=%b/%0d exp=1/2", ringing, ring_id); end
        pulse(0, 1);
    endtask

    task test_snooze;
        set_t(7, 0);
        cyc(4);
        pulse(1, 0);
        total++; if ({ringing, snoozing} !== 2'b01) begin bad++; $display("FAIL snooze_enter got=%b exp=01", {ringing, snoozing}); end
        wr(2, 7, 1, 0);
        cyc(5);
        total++; if ({ringing, snoozing} !== 2'b01) begin bad++; $display("FAIL snooze_hold got=%b exp=01", {ringing, snoozing}); end
        cyc(1);
        total++; if ({ringing, snoozing, ring_id, cur_minutes} !== {2'b10, 2'd2, 6'd3}) begin bad++; $display("FAIL snooze_return got=%b/%0d/%0d exp=10/2/3", {ringing, snoozing}, ring_id, cur_minutes); end
        pulse(0, 1);
        total++; if ({ringing, snoozing} !== 2'b00) begin bad++; $display("FAIL snooze_dismiss got=%b exp=00", {ringing, snoozing}); end
        pulse(1, 0);
        total++; if ({ringing, snoozing} !== 2'b00) begin bad++; $display("FAIL idle_snooze got=%b exp=00", {ringing, snoozing}); end
        wr(2, 7, 1, 1);
    endtask

    task test_timeout;
        set_t(7, 0);
        cyc(4);
        cyc(7);
        total++; if (ringing !== 1'b1) begin bad++; $display("FAIL before_timeout got=%b exp=1", ringing); end
        cyc(1);
        total++; if ({ringing, cur_minutes} !== {1'b0, 6'd3}) begin bad++; $display("FAIL timeout got=%b/%0d exp=0/3", ringing, cur_minutes); end
        set_t(7, 0);
        cyc(4);
        pulse(1, 1);
        total++; if ({ringing, snoozing} !== 2'b00) begin bad++; $display("FAIL snooze_and_dismiss got=%b exp=00", {ringing, snoozing}); end
        wr(3, 7, 3, 1);
        set_t(7, 0);
        cyc(12);
        total++; if ({ringing, ring_id} !== {1'b1, 2'd3}) begin bad++; $display("FAIL timeout_rematch got=%b/%0d exp=1/3", ringing, ring_id); end
        pulse(0, 1);
        wr(3, 7, 3, 0);
    endtask

    task test_reset_mid;
        set_t(7, 0);
        cyc(4);
        pulse(1, 0);
        total++; if (snoozing !== 1'b1) begin bad++; $display("FAIL pre_rst_snooze got=%b exp=1", snoozing); end
        rst = 1;
        cyc(1);
        rst = 0;
        total++; if ({cur_hours, cur_minutes, ringing, snoozing, buzzer, ring_id} !== 16'd0) begin bad++; $display("FAIL rst_mid got=%0d:%0d %b exp=0:0 00000", cur_hours, cur_minutes, {ringing, snoozing, buzzer, ring_id}); end
        set_t(7, 0);
        cyc(8);
        total++; if ({ringing, snoozing} !== 2'b00) begin bad++; $display("FAIL alarm_cleared got=%b exp=00", {ringing, snoozing}); end
    endtask

    initial begin
        test_reset;
        test_timekeeping;
        test_match;
        test_priority;
        test_snooze;
        test_timeout;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
